// File: rtl/dsp_mac_seq.sv
// Sequencer that drives the clock enables and OPMODE of a DSP48A1 slice for an N-term
// multiply-accumulate with AREG=BREG=MREG=PREG=1.
module dsp_mac_seq #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ce_ab,
  output logic             ce_m,
  output logic             ce_p,
  output logic             rst_p,
  output logic [7:0]       opmode,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             busy,
  output logic             err_len,
  output logic [1:0]       dbg_state
);

  // Handshakes: an operand pair transfers in any cycle where in_valid && in_ready;
  // the result transfers in any cycle where res_valid && res_ready.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t           state, state_nx;
  logic [LEN_W-1:0] remaining;
  logic             first_pend;
  logic             t1_v, t1_first, t2_v, t2_first;
  logic             accept;
  logic             launch;

  assign accept = in_valid & in_ready;
  assign launch = (state == IDLE) && start && (len != '0) && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      remaining  <= '0;
      first_pend <= 1'b0;
      t1_v       <= 1'b0;
      t1_first   <= 1'b0;
      t2_v       <= 1'b0;
      t2_first   <= 1'b0;
    end else begin
      state <= state_nx;
      if (launch) begin
        remaining  <= len;
        first_pend <= 1'b1;
      end else if (accept) begin
        remaining  <= remaining - 1'b1;
        first_pend <= 1'b0;
      end
      // Tag pipe mirrors the A/B -> M -> P register stages of the slice.
      t1_v     <= accept;
      t1_first <= accept & first_pend;
      t2_v     <= t1_v;
      t2_first <= t1_first;
    end
  end

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    rst_p    = 1'b0;
    err_len  = 1'b0;
    case (state)
      IDLE: begin
        if (start && !rst) begin
          if (len != '0) begin
            rst_p    = 1'b1;
            state_nx = LOAD;
          end else begin
            err_len = 1'b1;
          end
        end
      end
      LOAD: begin
        in_ready = (remaining != '0);
        if (in_valid && in_ready && (remaining == {{(LEN_W-1){1'b0}}, 1'b1}))
          state_nx = DRAIN;
      end
      // Stage 1 empty here means the final ce_p edge ends this cycle.
      DRAIN: begin
        if (!t1_v) state_nx = HOLD;
      end
      HOLD: begin
        if (res_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign ce_ab     = accept;
  assign ce_m      = t1_v;
  assign ce_p      = t2_v;
  assign opmode    = !t2_v ? 8'h00 : (t2_first ? 8'h01 : 8'h09);
  assign res_valid = (state == HOLD);
  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_dsp_mac_seq.sv
// Bench for dsp_mac_seq: a behavioural DSP48A1 slice driven by the sequencer outputs,
// with expected sums and OPMODE sequences queued by the driver and checked by a monitor.
module tb_dsp_mac_seq;
  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic             ce_ab, ce_m, ce_p, rst_p;
  logic [7:0]       opmode;
  logic             res_valid;
  logic             res_ready;
  logic             busy, err_len;
  logic [1:0]       dbg_state;
  logic [17:0]      a_in, b_in;

  dsp_mac_seq #(.LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid),
    .in_ready(in_ready), .ce_ab(ce_ab), .ce_m(ce_m), .ce_p(ce_p), .rst_p(rst_p),
    .opmode(opmode), .res_valid(res_valid), .res_ready(res_ready), .busy(busy),
    .err_len(err_len), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  logic [47:0] exp_q[$];
  logic [7:0]  exp_op_q[$];

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chkv(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural DSP48A1 slice ----------------
  logic        s_ab, s_m, s_p, s_rstp;
  logic [7:0]  s_op;
  logic [17:0] s_a, s_b;
  logic [17:0] a_r, b_r;
  logic [35:0] m_r;
  logic [47:0] p_r;

  always @(negedge clk) begin
    s_ab   <= ce_ab;
    s_m    <= ce_m;
    s_p    <= ce_p;
    s_rstp <= rst_p;
    s_op   <= opmode;
    s_a    <= a_in;
    s_b    <= b_in;
  end

  always @(posedge clk) begin
    if (s_ab) begin
      a_r <= s_a;
      b_r <= s_b;
    end
    if (s_m) m_r <= a_r * b_r;
    if (s_rstp) p_r <= '0;
    else if (s_p)
      p_r <= ((s_op[1:0] == 2'b01) ? {12'd0, m_r} : 48'd0) +
             ((s_op[3:2] == 2'b10) ? p_r : 48'd0);
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic prev_ab, prev_m;
    prev_ab = 1'b0;
    prev_m  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_ab = 1'b0;
        prev_m  = 1'b0;
      end else begin
        chk1("ce_m_follows_ce_ab", ce_m, prev_ab);
        chk1("ce_p_follows_ce_m", ce_p, prev_m);
        if (ce_p) begin
          checks++;
          if (exp_op_q.size() == 0) begin
            errors++;
            $display("FAIL opmode_unexpected: ce_p with opmode %0h but no term pending (cycle %0d)", opmode, cyc);
          end else begin
            checks--;
            chkv("opmode_term", 48'(opmode), 48'(exp_op_q.pop_front()));
          end
        end else begin
          chkv("opmode_no_ce_p", 48'(opmode), 48'd0);
        end
        if (res_valid && res_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL result_unexpected: handshake with P=%0h but no result pending (cycle %0d)", p_r, cyc);
          end else begin
            checks--;
            chkv("result_p", p_r, exp_q.pop_front());
          end
        end
        prev_ab = ce_ab;
        prev_m  = ce_m;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    #1 rst = 1'b1;
    exp_q.delete();
    exp_op_q.delete();
    @(posedge clk);
    #2 rst = 1'b0;
    tick();
  endtask

  task automatic len_zero_op();
    start = 1'b1; len = '0; in_valid = 1'b1;
    @(negedge clk);
    chk1("err_len_pulse", err_len, 1'b1);
    chk1("err_len_busy", busy, 1'b0);
    chk1("err_len_rst_p", rst_p, 1'b0);
    chk1("err_len_in_ready", in_ready, 1'b0);
    chk1("err_len_ce_ab", ce_ab, 1'b0);
    tick();
    start = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk1("err_len_one_cycle", err_len, 1'b0);
    chk1("err_len_still_idle", busy, 1'b0);
    tick();
  endtask

  // n terms; LOAD slot i stalls when stall_mask[i] or with stall_pct percent probability.
  task automatic run_op(input int n, input logic [31:0] stall_mask, input int stall_pct,
                        input int hold_n, input bit abort);
    int          left, last_acc, slot;
    bit          got;
    logic [47:0] sum;
    res_ready = 1'b0;
    start = 1'b1;
    len = n[LEN_W-1:0];
    @(negedge clk);
    chk1("start_rst_p", rst_p, 1'b1);
    chk1("start_busy", busy, 1'b0);
    chk1("start_err_len", err_len, 1'b0);
    tick();
    left = n; sum = '0; slot = 0; last_acc = 0;
    while (left > 0) begin
      in_valid = !((slot < 32 && stall_mask[slot]) || ($urandom_range(99) < stall_pct));
      a_in  = 18'($urandom);
      b_in  = 18'($urandom);
      start = 1'($urandom_range(1));
      len   = LEN_W'($urandom_range(1, 255));
      @(negedge clk);
      chk1("load_in_ready", in_ready, 1'b1);
      chk1("load_ce_ab", ce_ab, in_valid);
      chk1("load_busy", busy, 1'b1);
      if (in_valid) begin
        exp_op_q.push_back((left == n) ? 8'h01 : 8'h09);
        sum += a_in * b_in;
        left--;
        last_acc = cyc;
      end
      slot++;
      tick();
    end
    in_valid = 1'b1;
    start = 1'b0;
    if (abort) begin
      #1 rst = 1'b1;
      #1;
      chk1("abort_in_ready", in_ready, 1'b0);
      chk1("abort_ce_ab", ce_ab, 1'b0);
      chk1("abort_ce_m", ce_m, 1'b0);
      chk1("abort_ce_p", ce_p, 1'b0);
      chk1("abort_rst_p", rst_p, 1'b0);
      chk1("abort_res_valid", res_valid, 1'b0);
      chk1("abort_busy", busy, 1'b0);
      chk1("abort_err_len", err_len, 1'b0);
      chkv("abort_opmode", 48'(opmode), 48'd0);
      exp_op_q.delete();
      @(posedge clk);
      #2 rst = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk1("after_abort_busy", busy, 1'b0);
      chk1("after_abort_in_ready", in_ready, 1'b0);
      tick();
      return;
    end
    exp_q.push_back(sum);
    got = 1'b0;
    for (int w = 0; w < 20 && !got; w++) begin
      @(negedge clk);
      if (res_valid) got = 1'b1;
      else begin
        chk1("drain_no_accept", ce_ab, 1'b0);
        chk1("drain_busy", busy, 1'b1);
      end
    end
    if (!got) begin
      errors++; checks++;
      $display("FAIL res_valid_timeout: res_valid stayed 0 for 20 cycles after last term (cycle %0d)", cyc);
      pulse_reset();
      in_valid = 1'b0;
      return;
    end
    chkv("res_latency", 48'(cyc - last_acc), 48'd3);
    for (int h = 0; h < hold_n; h++) begin
      chk1("hold_res_valid", res_valid, 1'b1);
      chk1("hold_ce_p", ce_p, 1'b0);
      chk1("hold_ce_ab", ce_ab, 1'b0);
      chk1("hold_busy", busy, 1'b1);
      tick();
      start = 1'($urandom_range(1));
      len   = LEN_W'($urandom_range(1, 255));
      @(negedge clk);
    end
    chk1("hold_res_valid_last", res_valid, 1'b1);
    tick();
    res_ready = 1'b1;
    start = 1'b1;
    len = 8'd3;
    @(negedge clk);
    chk1("handshake_res_valid", res_valid, 1'b1);
    tick();
    res_ready = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk1("post_handshake_idle", busy, 1'b0);
    chk1("post_handshake_res_valid", res_valid, 1'b0);
    chk1("post_handshake_in_ready", in_ready, 1'b0);
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; start = 1'b1; len = '0; in_valid = 1'b1; res_ready = 1'b1;
    a_in = '0; b_in = '0;
    @(posedge clk); #2;
    chk1("reset_in_ready", in_ready, 1'b0);
    chk1("reset_ce_ab", ce_ab, 1'b0);
    chk1("reset_ce_m", ce_m, 1'b0);
    chk1("reset_ce_p", ce_p, 1'b0);
    chk1("reset_rst_p", rst_p, 1'b0);
    chk1("reset_res_valid", res_valid, 1'b0);
    chk1("reset_busy", busy, 1'b0);
    chk1("reset_err_len", err_len, 1'b0);
    chkv("reset_opmode", 48'(opmode), 48'd0);
    @(posedge clk); #2;
    start = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
    rst = 1'b0;
    tick();

    len_zero_op();
    run_op(1, 32'd0, 0, 0, 1'b0);
    run_op(4, 32'd0, 0, 5, 1'b0);
    run_op(3, 32'b10, 0, 1, 1'b0);
    run_op(4, 32'd0, 0, 0, 1'b1);
    run_op(2, 32'd0, 0, 2, 1'b0);
    for (int i = 0; i < 12; i++)
      run_op($urandom_range(1, 12), 32'd0, 30, $urandom_range(0, 4), 1'b0);
    len_zero_op();
    run_op(255, 32'd0, 10, 1, 1'b0);

    repeat (4) tick();
    checks++;
    if (exp_q.size() != 0 || exp_op_q.size() != 0) begin
      errors++;
      $display("FAIL queues_drained: results left %0d, terms left %0d", exp_q.size(), exp_op_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
